// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 16-bit byte-serial ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 4'b1001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;

endpackage

// File: rtl/alu_flags.sv
// Zero/sign/overflow flags for the assembled 16-bit result.
module alu_flags
  import alu_seq_pkg::*;
(
  input  logic              a_msb,
  input  logic              b_msb,
  input  logic [DATA_W-1:0] result,
  input  logic [OP_W-1:0]   op,
  input  logic              mode,
  output logic              zf_c,
  output logic              sf_c,
  output logic              vf_c
);

  always_comb begin
    zf_c = (result == DATA_W'(0));
    sf_c = result[DATA_W-1];
    vf_c = 1'b0;
    // Overflow is only meaningful for arithmetic add and subtract.
    if (!mode) begin
      if (op == OP_ADD)
        vf_c = (a_msb == b_msb) && (result[DATA_W-1] != a_msb);
      else if (op == OP_SUB)
        vf_c = (a_msb != b_msb) && (result[DATA_W-1] != a_msb);
    end
  end

endmodule

// File: rtl/alu_seq16.sv
// Runs a 16-bit operation through an external 8-bit ALU in two byte passes,
// chaining the raw carry from the low pass into the high pass.
module alu_seq16
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_mode,
  input  logic              req_cf,
  output logic [BYTE_W-1:0] alu_a,
  output logic [BYTE_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_mode,
  output logic              alu_cf_in,
  input  logic [BYTE_W-1:0] alu_out,
  input  logic              alu_cf_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cf,
  output logic              rsp_zf,
  output logic              rsp_sf,
  output logic              rsp_vf
);

  state_t            state;
  logic [BYTE_W-1:0] a_hi;
  logic [BYTE_W-1:0] b_hi;
  logic [BYTE_W-1:0] res_lo;
  logic              c_mid;
  logic              zf_c;
  logic              sf_c;
  logic              vf_c;

  // c_mid holds the carry for the pass in flight: the request carry in LO,
  // the low-byte carry out in HI.
  assign alu_cf_in = c_mid;

  alu_flags u_flags (
    .a_msb  (a_hi[BYTE_W-1]),
    .b_msb  (b_hi[BYTE_W-1]),
    .result ({alu_out, res_lo}),
    .op     (alu_op),
    .mode   (alu_mode),
    .zf_c   (zf_c),
    .sf_c   (sf_c),
    .vf_c   (vf_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cf     <= 1'b0;
      rsp_zf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_vf     <= 1'b0;
      a_hi       <= '0;
      b_hi       <= '0;
      res_lo     <= '0;
      c_mid      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_mode   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            // Low-byte drive values are loaded directly so LO sees them at once.
            alu_a     <= req_a[BYTE_W-1:0];
            alu_b     <= req_b[BYTE_W-1:0];
            a_hi      <= req_a[DATA_W-1:BYTE_W];
            b_hi      <= req_b[DATA_W-1:BYTE_W];
            alu_op    <= req_op;
            alu_mode  <= req_mode;
            c_mid     <= req_cf;
            req_ready <= 1'b0;
            state     <= LO;
          end
        end
        LO: begin
          res_lo <= alu_out;
          c_mid  <= alu_cf_out;
          alu_a  <= a_hi;
          alu_b  <= b_hi;
          state  <= HI;
        end
        HI: begin
          rsp_result <= {alu_out, res_lo};
          rsp_cf     <= alu_cf_out;
          rsp_zf     <= zf_c;
          rsp_sf     <= sf_c;
          rsp_vf     <= vf_c;
          rsp_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq16.sv
// Directed scoreboard bench for alu_seq16 driving a behavioural 74181-style 8-bit ALU.
module tb_alu_seq16;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        cf;
    logic        zf;
    logic        sf;
    logic        vf;
    logic        chk_cf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_op;
  logic        req_mode;
  logic        req_cf;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_op;
  logic        alu_mode;
  logic        alu_cf_in;
  logic [7:0]  alu_out;
  logic        alu_cf_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_cf;
  logic        rsp_zf;
  logic        rsp_sf;
  logic        rsp_vf;

  int   tests = 0;
  int   fails = 0;
  int   rsp_seen = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq16 dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_mode   (req_mode),
    .req_cf     (req_cf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_mode   (alu_mode),
    .alu_cf_in  (alu_cf_in),
    .alu_out    (alu_out),
    .alu_cf_out (alu_cf_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cf     (rsp_cf),
    .rsp_zf     (rsp_zf),
    .rsp_sf     (rsp_sf),
    .rsp_vf     (rsp_vf)
  );

  // 8-bit ALU, active-high data: carry in/out are active low (1 = no carry).
  function automatic logic [8:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] op, input logic mode,
                                      input logic cin);
    logic [8:0] s;
    logic [7:0] f;
    logic       co;
    s  = 9'd0;
    f  = a;
    co = 1'b1;
    case (op)
      4'b1001: begin
        s  = {1'b0, a} + {1'b0, b} + 9'(!cin);
        co = !s[8];
        f  = mode ? ~(a ^ b) : s[7:0];
      end
      4'b0110: begin
        s  = {1'b0, a} + {1'b0, ~b} + 9'(!cin);
        co = !s[8];
        f  = mode ? (a ^ b) : s[7:0];
      end
      default: begin
        f  = a;
        co = 1'b1;
      end
    endcase
    return {co, f};
  endfunction

  always_comb {alu_cf_out, alu_out} = alu8(alu_a, alu_b, alu_op, alu_mode, alu_cf_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop the oldest expectation whenever a response handshake is about to happen.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        rsp_seen++;
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        if (e.chk_cf) chk("rsp_cf", 32'(rsp_cf), 32'(e.cf));
        chk("rsp_zf", 32'(rsp_zf), 32'(e.zf));
        chk("rsp_sf", 32'(rsp_sf), 32'(e.sf));
        chk("rsp_vf", 32'(rsp_vf), 32'(e.vf));
      end
    end
  end

  // Drive a request until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      input logic mode, input logic cf, input exp_t e, input bit push);
    int n;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_mode  = mode;
    req_cf    = cf;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'(1));
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("idle_timeout", 32'(req_ready), 32'(1));
  endtask

  initial begin
    exp_t e;
    int   n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_mode  = 1'b0;
    req_cf    = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_result", 32'(rsp_result), 32'(0));
    chk("rst_flags", 32'({rsp_cf, rsp_zf, rsp_sf, rsp_vf}), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // add 0x00FF + 0x0001, with latency check: LO, HI, then DONE.
    e = '{res: 16'h0100, cf: 1'b1, zf: 1'b0, sf: 1'b0, vf: 1'b0, chk_cf: 1'b1};
    send(16'h00FF, 16'h0001, OP_ADD, 1'b0, 1'b1, e, 1'b1);
    chk("lat_lo_valid", 32'(rsp_valid), 32'(0));
    chk("lat_lo_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    chk("lat_hi_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    chk("lat_done_valid", 32'(rsp_valid), 32'(1));
    wait_idle();

    // sub 0x1000 - 0x0001: low-byte borrow chained into the high byte.
    e = '{res: 16'h0FFF, cf: 1'b0, zf: 1'b0, sf: 1'b0, vf: 1'b0, chk_cf: 1'b1};
    send(16'h1000, 16'h0001, OP_SUB, 1'b0, 1'b0, e, 1'b1);
    wait_idle();

    e = '{res: 16'h0000, cf: 1'b0, zf: 1'b1, sf: 1'b0, vf: 1'b0, chk_cf: 1'b1};
    send(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b1, e, 1'b1);
    wait_idle();

    e = '{res: 16'h8000, cf: 1'b1, zf: 1'b0, sf: 1'b1, vf: 1'b1, chk_cf: 1'b1};
    send(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b1, e, 1'b1);
    wait_idle();

    // add with active carry in (cf=0 means +1): 1 + 1 + 1.
    e = '{res: 16'h0003, cf: 1'b1, zf: 1'b0, sf: 1'b0, vf: 1'b0, chk_cf: 1'b1};
    send(16'h0001, 16'h0001, OP_ADD, 1'b0, 1'b0, e, 1'b1);
    wait_idle();

    // logic-mode xor; carry is don't-care here.
    e = '{res: 16'hFF00, cf: 1'b0, zf: 1'b0, sf: 1'b1, vf: 1'b0, chk_cf: 1'b0};
    send(16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b0, e, 1'b1);
    wait_idle();

    // Back-pressure: hold rsp_ready low in DONE with a second request pending.
    rsp_ready = 1'b0;
    e = '{res: 16'h2345, cf: 1'b1, zf: 1'b0, sf: 1'b0, vf: 1'b0, chk_cf: 1'b1};
    send(16'h1234, 16'h1111, OP_ADD, 1'b0, 1'b1, e, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reach_done", 32'(rsp_valid), 32'(1));
    req_a     = 16'h0005;
    req_b     = 16'h0003;
    req_op    = OP_SUB;
    req_mode  = 1'b0;
    req_cf    = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid), 32'(1));
      chk("stall_result", 32'(rsp_result), 32'(16'h2345));
      chk("stall_req_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_ready", 32'(req_ready), 32'(1));
    chk("post_hs_valid", 32'(rsp_valid), 32'(0));
    exp_q.push_back('{res: 16'h0002, cf: 1'b0, zf: 1'b0, sf: 1'b0, vf: 1'b0, chk_cf: 1'b1});
    @(posedge clk); #1;
    chk("second_accepted", 32'(req_ready), 32'(0));
    req_valid = 1'b0;
    wait_idle();

    // Reset while in HI abandons the operation with no response.
    e = '{res: 16'h0303, cf: 1'b1, zf: 1'b0, sf: 1'b0, vf: 1'b0, chk_cf: 1'b1};
    send(16'h0101, 16'h0202, OP_ADD, 1'b0, 1'b1, e, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", 32'(rsp_valid), 32'(0));
    chk("abort_ready", 32'(req_ready), 32'(1));
    chk("abort_result", 32'(rsp_result), 32'(0));
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) n++;
    end
    chk("abort_no_rsp", 32'(n), 32'(0));

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    chk("rsp_count", 32'(rsp_seen), 32'(8));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
